// File: rtl/regfile_scb_if.sv
// Bus between the core and the register file: decode-side read/reserve,
// writeback-side write, and the flush/ready control pair.
//   flush  : restart the clear sequence
//   rn     : NRD packed read addresses
//   q      : NRD packed read data
//   pend   : pending bit per read port
//   we/wn/d: write port
//   rsv/rsv_n : reserve (mark pending) port
//   ready  : 1 when the file is usable
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_scb_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic              flush;
  logic [NRD*AW-1:0] rn;
  logic [NRD*DW-1:0] q;
  logic [NRD-1:0]    pend;
  logic              we;
  logic [AW-1:0]     wn;
  logic [DW-1:0]     d;
  logic              rsv;
  logic [AW-1:0]     rsv_n;
  logic              ready;

  modport master (
    output flush, rn, we, wn, d, rsv, rsv_n,
    input  q, pend, ready
  );

  modport slave (
    input  flush, rn, we, wn, d, rsv, rsv_n,
    output q, pend, ready
  );
endinterface

// File: rtl/regfile_scb.sv
// Multi-read-port register file with same-cycle write bypass, per-register
// pending (scoreboard) bits and a sequenced clear engine that zeros one entry
// per cycle after clr or flush.
// Ports:
//   clk : clock, all state updates on posedge
//   clr : synchronous active-high reset
//   bus : regfile_scb_if slave (flush, rn/q/pend read ports, we/wn/d write
//         port, rsv/rsv_n reserve port, ready)
// Register 0 is hardwired to zero and never pending.
module regfile_scb #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          clr,
  regfile_scb_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic             ready_r;
  logic [DEPTH-1:0] pnd;
  logic [DW-1:0]    mem [DEPTH];

  logic restart;
  logic idle;
  logic wr_ok;
  logic rsv_ok;

  // clr and flush have the same effect; both restart the clear sequence.
  assign restart = clr | bus.flush;
  assign idle    = (state == IDLE);
  assign wr_ok   = idle && bus.we  && (bus.wn    != '0);
  assign rsv_ok  = idle && bus.rsv && (bus.rsv_n != '0);

  // Control: FSM, clear counter, pending bits, ready
  always_ff @(posedge clk) begin
    if (restart) begin
      state   <= CLEAR;
      cnt     <= '0;
      pnd     <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state   <= IDLE;
            ready_r <= 1'b1;
          end
        end
        IDLE: begin
          if (wr_ok)  pnd[bus.wn]    <= 1'b0;
          // Later assignment wins: a reserve in the same cycle as a write to
          // that register leaves it pending (the new producer is outstanding).
          if (rsv_ok) pnd[bus.rsv_n] <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Data: clear engine zeros entry cnt each CLEAR cycle, writeback in IDLE
  always_ff @(posedge clk) begin
    if (!restart) begin
      if (!idle)      mem[cnt]    <= '0;
      else if (wr_ok) mem[bus.wn] <= bus.d;
    end
  end

  assign bus.ready = ready_r;

  // Read ports: combinational, forced to zero during CLEAR and for r0
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    assign a   = bus.rn[i*AW +: AW];
    assign hit = (BYPASS != 0) && wr_ok && (bus.wn == a);

    assign bus.q[i*DW +: DW] = (!idle || a == '0) ? '0 :
                               hit                ? bus.d : mem[a];
    assign bus.pend[i]       = idle && (a != '0) && !hit && pnd[a];
  end
endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: reset/clear sequence timing, bypass vs
// no-bypass reads, r0 hardwiring, scoreboard reserve/write interaction,
// flush restart mid-sequence, plus random IDLE traffic on an NRD=3, AW=4
// instance checked against a reference model.
module tb_regfile_scb;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  regfile_scb_if #(.DW(32), .AW(5), .NRD(2)) b0 ();
  regfile_scb_if #(.DW(32), .AW(5), .NRD(2)) b1 ();
  regfile_scb_if #(.DW(16), .AW(4), .NRD(3)) b2 ();

  regfile_scb #(.DW(32), .AW(5), .NRD(2), .BYPASS(1)) u0 (.clk(clk), .clr(clr), .bus(b0));
  regfile_scb #(.DW(32), .AW(5), .NRD(2), .BYPASS(0)) u1 (.clk(clk), .clr(clr), .bus(b1));
  regfile_scb #(.DW(16), .AW(4), .NRD(3), .BYPASS(1)) u2 (.clk(clk), .clr(clr), .bus(b2));

  // The no-bypass instance sees exactly the same traffic as u0.
  assign b1.flush = b0.flush;
  assign b1.rn    = b0.rn;
  assign b1.we    = b0.we;
  assign b1.wn    = b0.wn;
  assign b1.d     = b0.d;
  assign b1.rsv   = b0.rsv;
  assign b1.rsv_n = b0.rsv_n;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        rsv;
    logic [4:0]  rsv_n;
    logic [4:0]  rn0;
    logic [4:0]  rn1;
    logic [31:0] q0;
    logic [31:0] q1;
    logic        p0;
    logic        p1;
    logic [31:0] q0nb;  // port 0 of the BYPASS=0 instance
  } vec_t;

  vec_t tv [14];

  logic [15:0] mdl [16];
  logic        mp  [16];
  logic [47:0] exq;
  logic [2:0]  exp_p;
  logic [3:0]  a;
  int n, n2;

  initial begin
    // Sequential vectors starting from an all-zero, nothing-pending file.
    tv[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tv[6]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd3, 32'h55,       32'h0,        1'b0, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 32'h55};
    tv[8]  = '{1'b1, 5'd9, 32'hAA,       1'b1, 5'd9, 5'd9, 5'd2, 32'hAA,       32'h0,        1'b0, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'hAA,       32'hAA,       1'b1, 1'b1, 32'hAA};
    tv[10] = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 5'd4, 5'd3, 32'h0,        32'h11,       1'b0, 1'b0, 32'h0};
    tv[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd3, 32'h0,        32'h11,       1'b1, 1'b0, 32'h0};
    tv[12] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 5'd4, 5'd9, 32'h44,       32'hAA,       1'b0, 1'b1, 32'h0};
    tv[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd9, 32'h44,       32'hAA,       1'b0, 1'b1, 32'h44};

    b0.flush = 1'b0; b0.rn = '0; b0.we = 1'b0; b0.wn = '0; b0.d = '0; b0.rsv = 1'b0; b0.rsv_n = '0;
    b2.flush = 1'b0; b2.rn = '0; b2.we = 1'b0; b2.wn = '0; b2.d = '0; b2.rsv = 1'b0; b2.rsv_n = '0;

    // Reset held 3 cycles, then the clear sequence runs DEPTH edges
    clr = 1'b1;
    cyc();
    chk("rst_ready", {63'b0, b0.ready}, 64'd0);
    cyc();
    cyc();
    clr = 1'b0;
    n = 0;
    n2 = 0;
    while (b0.ready !== 1'b1 && n < 100) begin
      b0.rn = {5'(n + 7), 5'(n)};
      @(negedge clk);
      chk("clr_q",    b0.q,    64'd0);
      chk("clr_pend", {62'b0, b0.pend}, 64'd0);
      cyc();
      n++;
      if (n2 == 0 && b2.ready === 1'b1) n2 = n;
    end
    chk("clr_len", 64'(n), 64'd32);
    chk("clr_len_aw4", 64'(n2), 64'd16);

    // Table: bypass, r0, scoreboard
    for (int i = 0; i < 14; i++) begin
      b0.we = tv[i].we; b0.wn = tv[i].wn; b0.d = tv[i].d;
      b0.rsv = tv[i].rsv; b0.rsv_n = tv[i].rsv_n;
      b0.rn = {tv[i].rn1, tv[i].rn0};
      @(negedge clk);
      chk($sformatf("v%0d_q0", i), {32'b0, b0.q[31:0]},  {32'b0, tv[i].q0});
      chk($sformatf("v%0d_q1", i), {32'b0, b0.q[63:32]}, {32'b0, tv[i].q1});
      chk($sformatf("v%0d_p0", i), {63'b0, b0.pend[0]}, {63'b0, tv[i].p0});
      chk($sformatf("v%0d_p1", i), {63'b0, b0.pend[1]}, {63'b0, tv[i].p1});
      chk($sformatf("v%0d_nobyp_q0", i), {32'b0, b1.q[31:0]}, {32'b0, tv[i].q0nb});
      chk($sformatf("v%0d_ready", i), {63'b0, b0.ready}, 64'd1);
      cyc();
    end
    b0.we = 1'b0; b0.rsv = 1'b0;

    // Fill r1..r31, reserve r12, then flush twice
    for (int i = 1; i < 32; i++) begin
      b0.we = 1'b1; b0.wn = 5'(i); b0.d = 32'(i);
      cyc();
    end
    b0.we = 1'b0;
    b0.rsv = 1'b1; b0.rsv_n = 5'd12;
    cyc();
    b0.rsv = 1'b0;
    b0.rn = {5'd31, 5'd12};
    @(negedge clk);
    chk("fill_q12",  {32'b0, b0.q[31:0]},  64'd12);
    chk("fill_q31",  {32'b0, b0.q[63:32]}, 64'd31);
    chk("fill_p12",  {63'b0, b0.pend[0]}, 64'd1);
    b0.flush = 1'b1;
    cyc();
    b0.flush = 1'b0;
    b0.we = 1'b1; b0.wn = 5'd20; b0.d = 32'hFFFFFFFF;
    b0.rsv = 1'b1; b0.rsv_n = 5'd12;
    for (int k = 0; k < 10; k++) begin
      b0.rn = {5'd1, 5'd20};
      @(negedge clk);
      chk("fl1_q",     b0.q, 64'd0);
      chk("fl1_pend",  {62'b0, b0.pend}, 64'd0);
      chk("fl1_ready", {63'b0, b0.ready}, 64'd0);
      cyc();
    end
    b0.flush = 1'b1;
    cyc();
    b0.flush = 1'b0;
    n = 0;
    while (b0.ready !== 1'b1 && n < 100) begin
      b0.wn = 5'((n % 31) + 1);
      b0.rn = {5'd12, 5'(n)};
      @(negedge clk);
      chk("fl2_q",    b0.q, 64'd0);
      chk("fl2_pend", {62'b0, b0.pend}, 64'd0);
      cyc();
      n++;
    end
    chk("flush_len", 64'(n), 64'd32);
    b0.we = 1'b0; b0.rsv = 1'b0;
    for (int i = 0; i < 32; i += 2) begin
      b0.rn = {5'(i + 1), 5'(i)};
      @(negedge clk);
      chk($sformatf("post_q_r%0d", i),    b0.q, 64'd0);
      chk($sformatf("post_pend_r%0d", i), {62'b0, b0.pend}, 64'd0);
      cyc();
    end

    // Random IDLE traffic on the NRD=3, AW=4 instance
    for (int i = 0; i < 16; i++) begin
      mdl[i] = '0;
      mp[i]  = 1'b0;
    end
    chk("r_ready", {63'b0, b2.ready}, 64'd1);
    for (int c = 0; c < 300; c++) begin
      b2.we    = 1'($urandom_range(0, 1));
      b2.wn    = 4'($urandom_range(0, 15));
      b2.d     = 16'($urandom);
      b2.rsv   = 1'($urandom_range(0, 1));
      b2.rsv_n = 4'($urandom_range(0, 15));
      for (int p = 0; p < 3; p++) begin
        // Bias one port towards the write address to exercise bypass.
        if (p == 0 && c % 3 == 0) b2.rn[3:0] = b2.wn;
        else b2.rn[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      for (int p = 0; p < 3; p++) begin
        a = b2.rn[p*4 +: 4];
        if (a == 4'd0) begin
          exq[p*16 +: 16] = '0;
          exp_p[p] = 1'b0;
        end else if (b2.we && b2.wn == a) begin
          exq[p*16 +: 16] = b2.d;
          exp_p[p] = 1'b0;
        end else begin
          exq[p*16 +: 16] = mdl[a];
          exp_p[p] = mp[a];
        end
      end
      @(negedge clk);
      chk($sformatf("rand%0d_q", c),    {16'b0, b2.q},    {16'b0, exq});
      chk($sformatf("rand%0d_pend", c), {61'b0, b2.pend}, {61'b0, exp_p});
      if (b2.we && b2.wn != 4'd0) begin
        mdl[b2.wn] = b2.d;
        mp[b2.wn]  = 1'b0;
      end
      if (b2.rsv && b2.rsv_n != 4'd0) mp[b2.rsv_n] = 1'b1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
